fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address loaded into the PC on reset.
REQ-002 SHALL have parameter MEM_WORDS, default 64, instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port stall, input, 1, hold the current instruction (no commit) this cycle.
REQ-006 SHALL have port branch_taken, input, 1, take the conditional branch at the end of this cycle.
REQ-007 SHALL have port branch_offset, input, 32, sign-extended word offset.
REQ-008 SHALL have port jump, input, 1, J-type jump.
REQ-009 SHALL have port jump_index, input, 26, J-type target field.
REQ-010 SHALL have port jump_reg, input, 1, JR-type jump.
REQ-011 SHALL have port jr_target, input, 32, register jump target.
REQ-012 SHALL have port imem_addr, output, 32, byte address to instruction memory (asynchronous read).
REQ-013 SHALL have port imem_instr, input, 32, instruction word returned by memory.
REQ-014 SHALL have port instr, output, 32, instruction to decode; 32'h0 whenever valid=0.
REQ-015 SHALL have ports pc and pc_plus4, output, 32 each, current PC and PC+4.
REQ-016 SHALL have port valid, output, 1, asserted when instr is an executable instruction.
REQ-017 SHALL have ports halted and fault, output, 1 each; fault_addr, output, 32, offending target.
REQ-018 SHALL have port retired, output, 32, count of committed instructions.

Function
REQ-019 SHALL implement a two-state machine, RUN and HALT; HALT is sticky until rst.
REQ-020 SHALL drive imem_addr = pc combinationally; instr = imem_instr when in RUN, else 32'h0.
REQ-021 SHALL assert valid = (state==RUN); halted = (state==HALT).
REQ-022 SHALL commit an instruction on a rising edge when state==RUN and stall==0; no commit otherwise.
REQ-023 SHALL select next PC on commit by priority jump_reg > jump > branch_taken > sequential.
REQ-024 SHALL compute targets modulo 2^32: sequential pc+4; branch pc+4+(branch_offset<<2); jump {pc_plus4[31:28], jump_index, 2'b00}; JR jr_target.
REQ-025 SHALL, on commit with a selected target whose bits [1:0] != 0 or whose value >= MEM_WORDS*4, leave pc unchanged, enter HALT, set fault=1, and load fault_addr with that target.
REQ-026 SHALL, on commit of instr == 32'h0000_000C (syscall), leave pc unchanged, enter HALT with fault=0; control inputs are ignored that cycle.
REQ-027 SHALL increment retired by 1 on every commit, including the committing syscall, with 32-bit wrap.
REQ-028 SHALL not increment retired on a faulting commit.
REQ-029 SHALL, when stall=1, hold pc and retired; control inputs are ignored.
REQ-030 SHALL, in HALT, ignore stall and all control inputs, and hold pc, retired, fault and fault_addr.

Reset
REQ-031 SHALL, with rst=1 at a rising edge, set pc=RESET_PC, state=RUN, fault=0, fault_addr=0, retired=0, taking priority over all other inputs, including mid-stall and in HALT.
REQ-032 SHALL present valid=1 and instr=imem_instr at RESET_PC in the first cycle after reset release.

Structure
REQ-033 SHALL take the state encoding, the SYSCALL word 32'h0000_000C and the NOP word 32'h0 from the shared package mips_pkg.
REQ-034 SHALL place target computation and priority selection in one combinational sub-module, next_pc_sel; the state machine, PC and counters stay in fetch_unit.

Verification
REQ-035 SHALL verify sequential fetch: after reset with no controls, 4 cycles -> pc 0,4,8,12; retired 0,1,2,3.
REQ-036 SHALL verify branch: at pc=8 with branch_taken=1 and branch_offset=32'hFFFF_FFFE -> next pc=4; with jump=1 and jump_index=5 in the same cycle -> pc=20.
REQ-037 SHALL verify stall: stall=1 for 3 cycles at pc=12 -> pc stays 12, retired unchanged, valid=1.
REQ-038 SHALL verify fault: at pc=0, jump_reg=1 and jr_target=32'h0000_0102 -> halted=1, fault=1, fault_addr=32'h102, pc=0, valid=0, instr=0; repeat with jr_target=32'h100 (MEM_WORDS=64) -> same outcome with fault_addr=32'h100.
REQ-039 SHALL verify syscall: imem_instr=32'h0000_000C at pc=16 -> halted=1, fault=0, pc=16, retired incremented once and then held.
REQ-040 SHALL verify reset from HALT: rst=1 for one cycle -> pc=RESET_PC, halted=0, fault=0, retired=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM encoding and the special instruction words.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC target computation and priority select (jump_reg > jump > branch > sequential).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the selected target is committed.
//
// Ports:
//   pc            current PC
//   branch_taken  / branch_offset  conditional branch, sign-extended word offset
//   jump          / jump_index     J-type jump, 26-bit target field
//   jump_reg      / jr_target      register jump
//   pc_plus4      pc + 4
//   next_pc       selected target (all arithmetic wraps modulo 2^32)
module next_pc_sel (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;

  assign pc_plus4     = pc + 32'd4;
  assign w_branch_tgt = pc_plus4 + (branch_offset << 2);
  // J-type keeps the 256 MB region of the delay-slot address.
  assign w_jump_tgt   = {pc_plus4[31:28], jump_index, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = w_jump_tgt;
    end else if (branch_taken) begin
      next_pc = w_branch_tgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, RUN/HALT state machine, retire counter, fault capture.
// Latency: imem_addr follows pc combinationally; the PC advances one commit per clock.
// Backpressure: stall=1 holds pc and retired; HALT ignores stall and controls until rst.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   stall                    hold the current instruction this cycle
//   branch_*, jump*, jr_*    control-flow requests, see next_pc_sel
//   imem_addr / imem_instr   asynchronous-read instruction memory
//   instr, valid             instruction to decode (zero when not valid)
//   pc, pc_plus4             current PC and PC+4
//   halted, fault, fault_addr  halt status and offending target
//   retired                  committed-instruction counter (wraps)
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] retired
);

  // 33 bits so the byte size cannot overflow the comparison.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_retired;
  logic         r_fault;
  logic [31:0]  r_fault_addr;

  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_retired_nxt;
  logic         w_fault_nxt;
  logic [31:0]  w_fault_addr_nxt;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target;
  logic         w_bad_target;
  logic         w_syscall;

  next_pc_sel u_next_pc_sel (
    .pc            (r_pc),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jr_target     (jr_target),
    .pc_plus4      (w_pc_plus4),
    .next_pc       (w_target)
  );

  assign w_bad_target = (w_target[1:0] != 2'b00) || ({1'b0, w_target} >= MEM_BYTES);
  assign w_syscall    = (imem_instr == SYSCALL_WORD);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_retired_nxt    = r_retired;
    w_fault_nxt      = r_fault;
    w_fault_addr_nxt = r_fault_addr;
    if (r_state == ST_RUN && !stall) begin
      if (w_syscall) begin
        // Syscall retires but PC stays on it; control inputs are ignored.
        w_state_nxt   = ST_HALT;
        w_retired_nxt = r_retired + 32'd1;
      end else if (w_bad_target) begin
        // Faulting commit does not retire.
        w_state_nxt      = ST_HALT;
        w_fault_nxt      = 1'b1;
        w_fault_addr_nxt = w_target;
      end else begin
        w_pc_nxt      = w_target;
        w_retired_nxt = r_retired + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_retired    <= 32'd0;
      r_fault      <= 1'b0;
      r_fault_addr <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_retired    <= w_retired_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_addr <= w_fault_addr_nxt;
    end
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign valid      = (r_state == ST_RUN);
  assign halted     = (r_state == ST_HALT);
  assign instr      = valid ? imem_instr : NOP_WORD;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
  assign retired    = r_retired;

endmodule
